// File: rtl/store_packer_pkg.sv
// Shared store encodings and the packed bus-write entry layout used by the
// store packer and its write FIFO.
package store_packer_pkg;

  // Store size encodings from the MEM stage.
  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_B    = 2'd1;
  localparam logic [1:0] ST_H    = 2'd2;
  localparam logic [1:0] ST_W    = 2'd3;

  localparam logic [3:0] BE_ALL  = 4'b1111;

  // One queued bus write: word address, lane-replicated data, byte enables.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } bus_entry_t;

  localparam int ENTRY_W = $bits(bus_entry_t);

endpackage

// File: rtl/store_fifo.sv
// Small synchronous FIFO with a registered head output. The head register
// always presents the oldest entry and keeps its last value once empty.
module store_fifo
  import store_packer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr, rptr_nxt;
  logic [OCC_W-1:0] count_q, remaining;
  logic [WIDTH-1:0] head_q, head_nxt;
  logic             do_push, do_pop;

  // Full is taken from the occupancy count so pointer equality is never ambiguous.
  assign full     = (count_q == OCC_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rptr_nxt = rptr + PTR_W'(do_pop);
  assign remaining = count_q - OCC_W'(do_pop);

  assign head_data = head_q;
  assign count     = count_q;

  // Next head: the next older entry if one survives the pop, else a fresh push into an empty queue.
  always_comb begin
    // NOTE: default assignment first so every path drives head_nxt and no latch is inferred.
    head_nxt = head_q;
    if (remaining != '0) begin
      head_nxt = mem[rptr_nxt];
    end else if (do_push) begin
      head_nxt = push_data;
    end
  end

  // Entry storage write port.
  // NOTE: the storage array is deliberately not reset; occupancy decides validity, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointers, occupancy and head register; reset overrides any push or pop.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_W'(1);
      end
      rptr   <= rptr_nxt;
      head_q <= head_nxt;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/store_packer.sv
// Packs sb/sh/sw stores into word-aligned, lane-replicated bus writes with
// byte enables, queues them, and drains them over a req/ack handshake.
// Misaligned stores raise a one-cycle AdES pulse and are dropped.
module store_packer
  import store_packer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [1:0]               st_op,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     bus_req,
  output logic [31:0]              bus_addr,
  output logic [31:0]              bus_wdata,
  output logic [3:0]               bus_be,
  input  logic                     bus_ack,
  output logic                     exc_ades,
  output logic [31:0]              exc_badvaddr,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [CNT_W-1:0]         st_count
);

  bus_entry_t packed_entry;
  bus_entry_t head;
  logic       aligned;
  logic       accept;
  logic       do_push;
  logic       misaligned;
  logic       fifo_full;
  logic       fifo_empty;

  // Lane selection, data replication and alignment check for the presented store.
  always_comb begin
    packed_entry.addr = {st_addr[31:2], 2'b00};
    packed_entry.data = '0;
    packed_entry.be   = '0;
    aligned           = 1'b1;
    case (st_op)
      ST_B: begin
        packed_entry.data = {4{st_data[7:0]}};
        packed_entry.be   = 4'b0001 << st_addr[1:0];
      end
      ST_H: begin
        aligned           = !st_addr[0];
        packed_entry.data = {2{st_data[15:0]}};
        packed_entry.be   = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      ST_W: begin
        aligned           = (st_addr[1:0] == 2'b00);
        packed_entry.data = st_data;
        packed_entry.be   = BE_ALL;
      end
      default: begin
        aligned = 1'b1;
      end
    endcase
  end

  // Ready depends only on occupancy; a full queue refuses even when a pop coincides.
  assign st_ready   = !fifo_full;
  assign accept     = st_valid && st_ready && (st_op != ST_NONE);
  assign do_push    = accept && aligned;
  assign misaligned = accept && !aligned;

  store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .push_data (packed_entry),
    .pop       (bus_ack),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending)
  );

  assign bus_req   = !fifo_empty;
  assign bus_addr  = head.addr;
  assign bus_wdata = head.data;
  assign bus_be    = head.be;

  // AdES pulse for a misaligned accepted store, latching the faulting address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exc_ades     <= 1'b0;
      exc_badvaddr <= '0;
    end else begin
      exc_ades <= misaligned;
      if (misaligned) begin
        exc_badvaddr <= st_addr;
      end
    end
  end

  // Count of stores committed to the queue, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_count <= '0;
    end else if (do_push) begin
      st_count <= st_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer: reset, packing, ordering under stall,
// misaligned exceptions, full-queue refusal, mid-drain reset and counter wrap.
module tb_store_packer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic        exc_ades;
  logic [31:0] exc_badvaddr;
  logic [1:0]  pending;
  logic [3:0]  st_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  store_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_op        (st_op),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .bus_req      (bus_req),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_ack      (bus_ack),
    .exc_ades     (exc_ades),
    .exc_badvaddr (exc_badvaddr),
    .pending      (pending),
    .st_count     (st_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_op    = op;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus_ack = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    tick(); tick();
    reset = 1'b1;
    total_cnt++; if (bus_req !== 1'b0) $display("FAIL rst_req: got %0h want 0", bus_req); else pass_cnt++;
    total_cnt++; if (pending !== 2'd0) $display("FAIL rst_pending: got %0h want 0", pending); else pass_cnt++;
    total_cnt++; if ({bus_addr, bus_wdata, bus_be} !== 68'h0) $display("FAIL rst_bus: got %h %h %h want 0", bus_addr, bus_wdata, bus_be); else pass_cnt++;
    total_cnt++; if ({exc_ades, exc_badvaddr, st_count} !== 37'h0) $display("FAIL rst_exc_cnt: got %0h %h %0h want 0", exc_ades, exc_badvaddr, st_count); else pass_cnt++;
    total_cnt++; if (st_ready !== 1'b1) $display("FAIL rst_ready: got %0h want 1", st_ready); else pass_cnt++;
  endtask

  task automatic test_sb_pack();
    bus_ack = 1'b1;
    drive(1'b1, 2'd1, 32'h0000_1003, 32'h1234_56AB);
    tick();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    total_cnt++; if (bus_req !== 1'b1) $display("FAIL sb_req: got %0h want 1", bus_req); else pass_cnt++;
    total_cnt++; if (bus_addr !== 32'h0000_1000) $display("FAIL sb_addr: got %h want 00001000", bus_addr); else pass_cnt++;
    total_cnt++; if (bus_wdata !== 32'hABAB_ABAB) $display("FAIL sb_wdata: got %h want ababab ab", bus_wdata); else pass_cnt++;
    total_cnt++; if (bus_be !== 4'b1000) $display("FAIL sb_be: got %b want 1000", bus_be); else pass_cnt++;
    total_cnt++; if (st_count !== 4'd1) $display("FAIL sb_count: got %0d want 1", st_count); else pass_cnt++;
    tick();
    total_cnt++; if (bus_req !== 1'b0 || pending !== 2'd0) $display("FAIL sb_drain: got req=%0h pend=%0d want 0 0", bus_req, pending); else pass_cnt++;
  endtask

  task automatic test_stall_order();
    bus_ack = 1'b0;
    drive(1'b1, 2'd2, 32'h0000_2002, 32'hFFFF_BEEF);
    tick();
    drive(1'b1, 2'd3, 32'h0000_2004, 32'hCAFE_F00D);
    tick();
    total_cnt++; if (pending !== 2'd2 || st_ready !== 1'b0) $display("FAIL stall_full: got pend=%0d rdy=%0h want 2 0", pending, st_ready); else pass_cnt++;
    total_cnt++; if ({bus_addr, bus_wdata, bus_be} !== {32'h0000_2000, 32'hBEEF_BEEF, 4'b1100}) $display("FAIL stall_head: got %h %h %b want 00002000 beefbeef 1100", bus_addr, bus_wdata, bus_be); else pass_cnt++;
    // Third store is presented while full and must stall.
    drive(1'b1, 2'd1, 32'h0000_2008, 32'h0000_0077);
    tick();
    total_cnt++; if (pending !== 2'd2 || st_count !== 4'd3) $display("FAIL stall_hold: got pend=%0d cnt=%0d want 2 3", pending, st_count); else pass_cnt++;
    total_cnt++; if ({bus_addr, bus_wdata, bus_be} !== {32'h0000_2000, 32'hBEEF_BEEF, 4'b1100}) $display("FAIL stall_stable: got %h %h %b want 00002000 beefbeef 1100", bus_addr, bus_wdata, bus_be); else pass_cnt++;
    // Full with ack and valid together: pop only, no bypass push.
    bus_ack = 1'b1;
    tick();
    total_cnt++; if (pending !== 2'd1 || st_ready !== 1'b1 || st_count !== 4'd3) $display("FAIL full_ack: got pend=%0d rdy=%0h cnt=%0d want 1 1 3", pending, st_ready, st_count); else pass_cnt++;
    total_cnt++; if ({bus_addr, bus_wdata, bus_be} !== {32'h0000_2004, 32'hCAFE_F00D, 4'b1111}) $display("FAIL order_sw: got %h %h %b want 00002004 cafef00d 1111", bus_addr, bus_wdata, bus_be); else pass_cnt++;
    // Now not full: push and pop together keep occupancy and order.
    tick();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    total_cnt++; if (pending !== 2'd1 || st_count !== 4'd4) $display("FAIL pushpop: got pend=%0d cnt=%0d want 1 4", pending, st_count); else pass_cnt++;
    total_cnt++; if ({bus_addr, bus_wdata, bus_be} !== {32'h0000_2008, 32'h7777_7777, 4'b0001}) $display("FAIL order_sb: got %h %h %b want 00002008 77777777 0001", bus_addr, bus_wdata, bus_be); else pass_cnt++;
    tick();
    total_cnt++; if (bus_req !== 1'b0 || bus_addr !== 32'h0000_2008) $display("FAIL empty_hold: got req=%0h addr=%h want 0 00002008", bus_req, bus_addr); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    bus_ack = 1'b0;
    drive(1'b1, 2'd2, 32'h0000_3001, 32'h1111_2222);
    tick();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    total_cnt++; if (exc_ades !== 1'b1 || exc_badvaddr !== 32'h0000_3001) $display("FAIL ades_sh: got exc=%0h bad=%h want 1 00003001", exc_ades, exc_badvaddr); else pass_cnt++;
    total_cnt++; if (bus_req !== 1'b0 || pending !== 2'd0 || st_count !== 4'd4) $display("FAIL ades_sh_nopush: got req=%0h pend=%0d cnt=%0d want 0 0 4", bus_req, pending, st_count); else pass_cnt++;
    tick();
    total_cnt++; if (exc_ades !== 1'b0 || exc_badvaddr !== 32'h0000_3001) $display("FAIL ades_pulse: got exc=%0h bad=%h want 0 00003001", exc_ades, exc_badvaddr); else pass_cnt++;
    drive(1'b1, 2'd3, 32'h0000_3002, 32'h3333_4444);
    tick();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    total_cnt++; if (exc_ades !== 1'b1 || exc_badvaddr !== 32'h0000_3002 || bus_req !== 1'b0) $display("FAIL ades_sw: got exc=%0h bad=%h req=%0h want 1 00003002 0", exc_ades, exc_badvaddr, bus_req); else pass_cnt++;
    tick();
    total_cnt++; if (exc_ades !== 1'b0 || st_count !== 4'd4) $display("FAIL ades_sw_end: got exc=%0h cnt=%0d want 0 4", exc_ades, st_count); else pass_cnt++;
    // ST_NONE with valid is ignored entirely.
    drive(1'b1, 2'd0, 32'h0000_3003, 32'h5555_6666);
    tick();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    total_cnt++; if (exc_ades !== 1'b0 || pending !== 2'd0 || st_count !== 4'd4 || exc_badvaddr !== 32'h0000_3002) $display("FAIL st_none: got exc=%0h pend=%0d cnt=%0d bad=%h want 0 0 4 00003002", exc_ades, pending, st_count, exc_badvaddr); else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    bus_ack = 1'b0;
    drive(1'b1, 2'd1, 32'h0000_4000, 32'h0000_0011);
    tick();
    drive(1'b1, 2'd1, 32'h0000_4001, 32'h0000_0022);
    tick();
    total_cnt++; if (pending !== 2'd2 || bus_req !== 1'b1) $display("FAIL pre_rst: got pend=%0d req=%0h want 2 1", pending, bus_req); else pass_cnt++;
    reset = 1'b0; bus_ack = 1'b1;
    tick();
    total_cnt++; if (bus_req !== 1'b0 || pending !== 2'd0 || st_count !== 4'd0) $display("FAIL mid_rst: got req=%0h pend=%0d cnt=%0d want 0 0 0", bus_req, pending, st_count); else pass_cnt++;
    total_cnt++; if (exc_ades !== 1'b0 || st_ready !== 1'b1 || bus_addr !== 32'h0) $display("FAIL mid_rst_misc: got exc=%0h rdy=%0h addr=%h want 0 1 0", exc_ades, st_ready, bus_addr); else pass_cnt++;
    reset = 1'b1; bus_ack = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_count_wrap();
    logic [67:0] exp_q [$];
    logic [67:0] exp_e;
    logic [31:0] a;
    logic [7:0]  d;
    int          popped = 0;
    bus_ack = 1'b1;
    for (int i = 0; i < 19; i++) begin
      a = 32'h0000_5000 + 32'(i);
      d = 8'(8'h10 + i);
      if (bus_req && bus_ack) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL wrap_extra: got %h %h %b want no entry", bus_addr, bus_wdata, bus_be);
        else begin
          exp_e = exp_q.pop_front();
          if ({bus_addr, bus_wdata, bus_be} !== exp_e) $display("FAIL wrap_entry: got %h want %h", {bus_addr, bus_wdata, bus_be}, exp_e);
          else pass_cnt++;
        end
        popped++;
      end
      drive(1'b1, 2'd1, a, {24'hABCDEF, d});
      exp_q.push_back({a & 32'hFFFF_FFFC, {4{d}}, 4'(4'b0001 << a[1:0])});
      tick();
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    for (int k = 0; k < 8 && bus_req; k++) begin
      total_cnt++;
      if (exp_q.size() == 0) $display("FAIL wrap_extra: got %h %h %b want no entry", bus_addr, bus_wdata, bus_be);
      else begin
        exp_e = exp_q.pop_front();
        if ({bus_addr, bus_wdata, bus_be} !== exp_e) $display("FAIL wrap_entry: got %h want %h", {bus_addr, bus_wdata, bus_be}, exp_e);
        else pass_cnt++;
      end
      popped++;
      tick();
    end
    total_cnt++; if (bus_req !== 1'b0) $display("FAIL wrap_timeout: got req=%0h want 0", bus_req); else pass_cnt++;
    total_cnt++; if (popped != 19 || exp_q.size() != 0) $display("FAIL wrap_total: got popped=%0d left=%0d want 19 0", popped, exp_q.size()); else pass_cnt++;
    total_cnt++; if (st_count !== 4'd3) $display("FAIL wrap_count: got %0d want 3", st_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sb_pack();
    test_stall_order();
    test_misaligned();
    test_reset_mid_drain();
    test_count_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
